// File: rtl/inv_dir_scheduler.sv
// Arbitrates two ray requesters onto one shared 1/dir divider and returns one result at a time.
// Optional watchdog on the divider wait: define INV_DIR_SCHED_TIMEOUT_EN (adds the err port).
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif

module inv_dir_scheduler #(
  parameter int WIDTH   = `WIDTH,
  parameter int Q_BITS  = `Q_BITS,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [3*WIDTH-1:0] req0_rd,
  input  logic [3*WIDTH-1:0] req1_rd,
  input  logic               req0_skip,
  input  logic               req1_skip,
  output logic               div_start,
  output logic [3*WIDTH-1:0] div_rd,
  output logic               div_skip,
  input  logic               div_valid,
  input  logic [3*WIDTH-1:0] div_rd_q,
  input  logic               div_skip_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*WIDTH-1:0] out_rd,
  output logic               out_skip,
  output logic               out_id,
  output logic               busy
`ifdef INV_DIR_SCHED_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t             state, state_next;
  logic               ptr;
  logic               grant, sel, sel_skip;
  logic               timeout;
  logic [3*WIDTH-1:0] rd_r, res_rd;
  logic               skip_r, res_skip, id_r;

  if (Q_BITS < 1 || Q_BITS >= WIDTH || TIMEOUT < 1) begin : g_param_check
    $error("inv_dir_scheduler: illegal Q_BITS/WIDTH/TIMEOUT combination");
  end

  // Round-robin: the pointer only matters when both requesters are valid.
  always_comb begin
    grant = req0_valid | req1_valid;
    if (req0_valid && req1_valid) sel = ptr;
    else                          sel = req1_valid;
    sel_skip = sel ? req1_skip : req0_skip;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = sel_skip ? RESULT : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (div_valid || timeout) state_next = RESULT;
      RESULT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, even before the first reset edge.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    div_start  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      req0_ready = (state == IDLE) && grant && !sel;
      req1_ready = (state == IDLE) && grant &&  sel;
      div_start  = (state == ISSUE);
      out_valid  = (state == RESULT);
      busy       = (state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= 1'b0;
      rd_r     <= '0;
      skip_r   <= 1'b0;
      id_r     <= 1'b0;
      res_rd   <= '0;
      res_skip <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          ptr    <= ~sel;
          id_r   <= sel;
          rd_r   <= sel ? req1_rd : req0_rd;
          skip_r <= sel_skip;
          if (sel_skip) begin
            res_rd   <= '0;
            res_skip <= 1'b1;
          end
        end
        WAIT: if (div_valid) begin
          res_rd   <= div_rd_q;
          res_skip <= div_skip_q;
        end else if (timeout) begin
          res_rd   <= '0;
          res_skip <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef INV_DIR_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_r;

  // Fires on the TIMEOUT-th consecutive WAIT cycle without a divider result.
  assign timeout = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      if (state == WAIT && !div_valid) wd_cnt <= wd_cnt + 1'b1;
      else                             wd_cnt <= '0;
      if (state == WAIT && !div_valid && timeout) err_r <= 1'b1;
      else if (state == RESULT && out_ready)      err_r <= 1'b0;
    end
  end

  assign err = err_r;
`else
  assign timeout = 1'b0;
`endif

  assign div_rd   = rd_r;
  assign div_skip = skip_r;
  assign out_rd   = res_rd;
  assign out_skip = res_skip;
  assign out_id   = id_r;

endmodule
